spi_arb: RTL

- Shares the single SPI master peripheral between three digital-core requesters:
  - req 0: command processor (pot/EEPROM commands from HOST)
  - req 1: calibration loader (EEPROM reads for channel gain/offset)
  - req 2: trigger-level refresher (trig pot writes)
- Round-robin arbitration, one SPI transaction per grant.
- Drives SPI_data/ss/wrt_SPI and returns completion plus EEPROM read byte to the granted requester.
- Enforces a minimum inter-transaction gap and a transaction timeout.

---
 rtl/spi_arb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/spi_arb.sv
// Round-robin arbiter sharing one SPI master between three requesters, with timeout and inter-transaction gap.
// Optional macro SPI_LOCK_EN: a requester holding req_lock at completion keeps the grant for a back-to-back transaction.
module spi_arb #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int IDLE_GAP    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [47:0] req_data,
    input  logic [8:0]  req_ss,
    input  logic [2:0]  req_lock,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic [7:0]  rd_data,
    output logic        to_err,
    output logic        err_sticky,
    input  logic        clr_err,
    output logic [15:0] SPI_data,
    output logic [2:0]  ss,
    output logic        wrt_SPI,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data,
    output logic        busy
);

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [2:0]     gnt_q, gnt_d;
    logic [2:0]     done_q, done_d;
    logic           to_err_q, to_err_d;
    logic           err_q, err_d;
    logic [15:0]    data_q, data_d;
    logic [2:0]     ss_q, ss_d;
    logic           wrt_q, wrt_d;
    logic [7:0]     rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    gap_q, gap_d;

    logic [15:0]    data_arr [3];
    logic [2:0]     ss_arr   [3];
    logic [1:0]     order    [3];
    logic [1:0]     win_idx;
    logic [2:0]     win_oh;
    logic           win_found;

    for (genvar gi = 0; gi < 3; gi++) begin : g_split
        assign data_arr[gi] = req_data[16*gi +: 16];
        assign ss_arr[gi]   = req_ss[3*gi +: 3];
    end

`ifndef SPI_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Search order starts one past the last winner so every requester gets a turn.
    always_comb begin
        case (ptr_q)
            2'd0:    order = '{2'd1, 2'd2, 2'd0};
            2'd1:    order = '{2'd2, 2'd0, 2'd1};
            default: order = '{2'd0, 2'd1, 2'd2};
        endcase
        win_idx   = 2'd0;
        win_oh    = 3'b000;
        win_found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!win_found && req[order[k]]) begin
                win_found = 1'b1;
                win_idx   = order[k];
                win_oh    = 3'b001 << order[k];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = 3'b000;
        to_err_d = 1'b0;
        err_d    = err_q;
        data_d   = data_q;
        ss_d     = ss_q;
        wrt_d    = 1'b0;
        rd_d     = rd_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;

        if (clr_err) begin
            err_d = 1'b0;
        end
        // Grant covers the completion pulse clock, then drops.
        if (|done_q) begin
            gnt_d = 3'b000;
        end

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LAUNCH;
                    ptr_d   = win_idx;
                    gnt_d   = win_oh;
                    data_d  = data_arr[win_idx];
                    ss_d    = ss_arr[win_idx];
                    wrt_d   = 1'b1;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (SPI_done) begin
                    rd_d    = EEP_data;
                    done_d  = gnt_q;
                    state_d = (IDLE_GAP == 0) ? IDLE : GAP;
                    gap_d   = '0;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    rd_d     = 8'hFF;
                    done_d   = gnt_q;
                    to_err_d = 1'b1;
                    err_d    = 1'b1;
                    state_d  = (IDLE_GAP == 0) ? IDLE : GAP;
                    gap_d    = '0;
                end
            end
            GAP: begin
                gap_d = gap_q + 32'd1;
                if (gap_q == 32'(IDLE_GAP - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SPI_LOCK_EN
        // Locked requester re-launches straight from its done clock with fresh data.
        if ((|done_q) && req[ptr_q] && req_lock[ptr_q]) begin
            state_d = LAUNCH;
            ptr_d   = ptr_q;
            gnt_d   = gnt_q;
            data_d  = data_arr[ptr_q];
            ss_d    = ss_arr[ptr_q];
            wrt_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd2;
            gnt_q    <= 3'b000;
            done_q   <= 3'b000;
            to_err_q <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= 16'h0000;
            ss_q     <= 3'b000;
            wrt_q    <= 1'b0;
            rd_q     <= 8'h00;
            cnt_q    <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            to_err_q <= to_err_d;
            err_q    <= err_d;
            data_q   <= data_d;
            ss_q     <= ss_d;
            wrt_q    <= wrt_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rd_data    = rd_q;
    assign to_err     = to_err_q;
    assign err_sticky = err_q;
    assign SPI_data   = data_q;
    assign ss         = ss_q;
    assign wrt_SPI    = wrt_q;
    assign busy       = (state_q != IDLE);

endmodule
